// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared constants and packer FSM encoding for the MLP output path
package mlp_pkg;

    // Defaults shared with the argmax stage so both ends agree on lane order and width.
    localparam int unsigned MLP_NUM_INPUT   = 10;
    localparam int unsigned MLP_INPUT_WIDTH = 16;

    typedef enum logic {
        PACK_IDLE  = 1'b0,
        PACK_GUARD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/layer_output_packer_if.sv
// rtl/layer_output_packer_if.sv - serial word input and packed frame output bundle (PACKER_LAST_CHECK_EN adds i_last/o_frame_err)
interface layer_output_packer_if
    import mlp_pkg::*;
#(
    parameter int unsigned numInput   = MLP_NUM_INPUT,
    parameter int unsigned inputWidth = MLP_INPUT_WIDTH
);
    logic [inputWidth-1:0]          i_data;
    logic                           i_valid;
    logic [numInput*inputWidth-1:0] o_data;
    logic                           o_data_valid;
    logic                           o_overrun;
`ifdef PACKER_LAST_CHECK_EN
    logic                           i_last;
    logic                           o_frame_err;

    modport master (output i_data, i_valid, i_last,
                    input  o_data, o_data_valid, o_overrun, o_frame_err);
    modport slave  (input  i_data, i_valid, i_last,
                    output o_data, o_data_valid, o_overrun, o_frame_err);
`else
    modport master (output i_data, i_valid,
                    input  o_data, o_data_valid, o_overrun);
    modport slave  (input  i_data, i_valid,
                    output o_data, o_data_valid, o_overrun);
`endif
endinterface

// File: rtl/packer_frame_collector.sv
// rtl/packer_frame_collector.sv - gathers serial words into a frame buffer (PACKER_LAST_CHECK_EN adds framing check)
module packer_frame_collector
    import mlp_pkg::*;
#(
    parameter int unsigned numInput   = MLP_NUM_INPUT,
    parameter int unsigned inputWidth = MLP_INPUT_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [inputWidth-1:0]          i_data,
    input  logic                           i_valid,
`ifdef PACKER_LAST_CHECK_EN
    input  logic                           i_last,
    output logic                           o_frame_err,
`endif
    output logic [numInput*inputWidth-1:0] o_frame,
    output logic                           o_frame_done
);

    localparam int unsigned      CNT_W     = (numInput > 1) ? $clog2(numInput) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(numInput - 1);

    logic [CNT_W-1:0]               wr_cnt_q, wr_cnt_d;
    logic [numInput*inputWidth-1:0] collect_q, collect_d;
    logic                           at_last;
    logic                           accept;
`ifdef PACKER_LAST_CHECK_EN
    logic                           frame_err_q, frame_err_d;
`endif

    // Lane write and word counter; the completed frame is exposed combinationally so the
    // final word reaches the pending slot on the same edge it is sampled.
    always_comb begin
        at_last   = (wr_cnt_q == LAST_LANE);
        accept    = i_valid;
        wr_cnt_d  = wr_cnt_q;
        collect_d = collect_q;
`ifdef PACKER_LAST_CHECK_EN
        frame_err_d = i_valid && (i_last != at_last);
        accept      = i_valid && !frame_err_d;
        if (frame_err_d) begin
            wr_cnt_d = '0;
        end
`endif
        if (accept) begin
            for (int k = 0; k < numInput; k++) begin
                if (wr_cnt_q == CNT_W'(k)) begin
                    collect_d[k*inputWidth +: inputWidth] = i_data;
                end
            end
            wr_cnt_d = at_last ? '0 : wr_cnt_q + CNT_W'(1);
        end
    end

    assign o_frame      = collect_d;
    assign o_frame_done = accept && at_last;

    // Collector state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt_q    <= '0;
            collect_q   <= '0;
`ifdef PACKER_LAST_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            collect_q   <= collect_d;
`ifdef PACKER_LAST_CHECK_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

`ifdef PACKER_LAST_CHECK_EN
    assign o_frame_err = frame_err_q;
`endif

endmodule

// File: rtl/layer_output_packer.sv
// rtl/layer_output_packer.sv - packs a layer's serial outputs into one guarded frame pulse for argmax (PACKER_LAST_CHECK_EN optional)
module layer_output_packer
    import mlp_pkg::*;
#(
    parameter int unsigned numInput    = MLP_NUM_INPUT,
    parameter int unsigned inputWidth  = MLP_INPUT_WIDTH,
    parameter int unsigned guardCycles = numInput + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    layer_output_packer_if.slave  bus
);

    localparam int unsigned NW         = numInput * inputWidth;
    localparam int unsigned GUARD_INIT = (guardCycles > 0) ? guardCycles - 1 : 0;
    localparam int unsigned GW         = (GUARD_INIT > 0) ? $clog2(GUARD_INIT + 1) : 1;

    logic [NW-1:0] frame;
    logic          frame_done;

    pack_state_e   state_q, state_d;
    logic [GW-1:0] guard_cnt_q, guard_cnt_d;
    logic          pend_full_q, pend_full_d;
    logic [NW-1:0] pend_data_q, pend_data_d;
    logic [NW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;
    logic          drain;

    packer_frame_collector #(
        .numInput   (numInput),
        .inputWidth (inputWidth)
    ) u_collector (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_data       (bus.i_data),
        .i_valid      (bus.i_valid),
`ifdef PACKER_LAST_CHECK_EN
        .i_last       (bus.i_last),
        .o_frame_err  (bus.o_frame_err),
`endif
        .o_frame      (frame),
        .o_frame_done (frame_done)
    );

    // Emitter FSM and pending slot: a frame arriving while the slot drains is accepted,
    // otherwise it is dropped and flagged so the in-flight frame is never overwritten.
    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overrun_d   = 1'b0;
        drain       = 1'b0;
        case (state_q)
            PACK_IDLE: begin
                if (pend_full_q) begin
                    out_data_d  = pend_data_q;
                    out_valid_d = 1'b1;
                    drain       = 1'b1;
                    pend_full_d = 1'b0;
                    guard_cnt_d = GW'(GUARD_INIT);
                    state_d     = PACK_GUARD;
                end
            end
            PACK_GUARD: begin
                if (guard_cnt_q == '0) begin
                    state_d = PACK_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - GW'(1);
                end
            end
            default: state_d = PACK_IDLE;
        endcase
        if (frame_done) begin
            if (!pend_full_q || drain) begin
                pend_data_d = frame;
                pend_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Emitter, pending slot and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= PACK_IDLE;
            guard_cnt_q <= '0;
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.o_data       = out_data_q;
    assign bus.o_data_valid = out_valid_q;
    assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_layer_output_packer.sv
// tb/tb_layer_output_packer.sv - scoreboard bench for layer_output_packer (PACKER_LAST_CHECK_EN aware)
module tb_layer_output_packer;
    import mlp_pkg::*;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int NW = N * W;

    typedef struct {
        logic [NW-1:0] data;
        int            at;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] d     = '0;
    logic         v     = 1'b0;
    logic         l     = 1'b0;

    always #5 clk = ~clk;

    layer_output_packer_if #(.numInput(N), .inputWidth(W)) bus [2] ();

    logic [NW-1:0] od   [2];
    logic          oval [2];
    logic          oovr [2];
    logic          oerr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        layer_output_packer #(
            .numInput    (N),
            .inputWidth  (W),
            .guardCycles ((g == 0) ? N + 1 : 40)
        ) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus[g])
        );
        assign bus[g].i_data  = d;
        assign bus[g].i_valid = v;
        assign od[g]   = bus[g].o_data;
        assign oval[g] = bus[g].o_data_valid;
        assign oovr[g] = bus[g].o_overrun;
`ifdef PACKER_LAST_CHECK_EN
        assign bus[g].i_last = l;
        assign oerr[g] = bus[g].o_frame_err;
`else
        assign oerr[g] = 1'b0;
`endif
    end

    // Behavioural reference: frame counting, one pending slot, emission time from spacing rules.
    int            edge_n = 0;
    logic [W-1:0]  mbuf [2][N];
    int            mcnt [2];
    bit            mpend [2];
    logic [NW-1:0] mpend_data [2];
    int            mpend_emit [2];
    int            mlast [2];
    exp_t          q_data [2][$];
    int            q_ov [2][$];
    int            q_er [2][$];

    int n_cmp = 0;
    int n_bad = 0;
    bit fin_req = 0;
    bit fin_done = 0;
    logic [NW-1:0] prev_data [2];

    function automatic int guard_of(int k);
        return (k == 0) ? N + 1 : 40;
    endfunction

    function automatic logic [NW-1:0] pack_buf(int k);
        logic [NW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = mbuf[k][i];
        return r;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mcnt[k]  = 0;
                mpend[k] = 0;
                mlast[k] = -1000;
            end else begin
                if (mpend[k] && mpend_emit[k] == edge_n) begin
                    q_data[k].push_back('{mpend_data[k], edge_n});
                    mlast[k] = edge_n;
                    mpend[k] = 0;
                end
                if (v) begin
                    bit bad;
                    bad = 0;
`ifdef PACKER_LAST_CHECK_EN
                    bad = (l != (mcnt[k] == N - 1));
`endif
                    if (bad) begin
                        q_er[k].push_back(edge_n);
                        mcnt[k] = 0;
                    end else begin
                        mbuf[k][mcnt[k]] = d;
                        if (mcnt[k] == N - 1) begin
                            mcnt[k] = 0;
                            if (!mpend[k]) begin
                                int e;
                                e = mlast[k] + guard_of(k) + 1;
                                mpend[k]      = 1;
                                mpend_data[k] = pack_buf(k);
                                mpend_emit[k] = (edge_n + 1 > e) ? edge_n + 1 : e;
                            end else begin
                                q_ov[k].push_back(edge_n);
                            end
                        end else begin
                            mcnt[k]++;
                        end
                    end
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: pops expected events whenever a DUT output pulses, flags late or missing ones.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                cmp($sformatf("rst_valid%0d", k), NW'(oval[k]), '0);
                cmp($sformatf("rst_overrun%0d", k), NW'(oovr[k]), '0);
                cmp($sformatf("rst_data%0d", k), od[k], '0);
                q_data[k].delete();
                q_ov[k].delete();
                q_er[k].delete();
                prev_data[k] = '0;
            end else begin
                if (oval[k]) begin
                    if (q_data[k].size() == 0) begin
                        cmp($sformatf("unexpected_pulse%0d", k), NW'(1), '0);
                    end else begin
                        exp_t e;
                        e = q_data[k].pop_front();
                        cmp($sformatf("frame_data%0d", k), od[k], e.data);
                        cmp($sformatf("frame_edge%0d", k), NW'(edge_n), NW'(e.at));
                    end
                end else begin
                    cmp($sformatf("data_stable%0d", k), od[k], prev_data[k]);
                end
                prev_data[k] = od[k];
                if (oovr[k]) begin
                    if (q_ov[k].size() == 0) cmp($sformatf("unexpected_overrun%0d", k), NW'(1), '0);
                    else cmp($sformatf("overrun_edge%0d", k), NW'(edge_n), NW'(q_ov[k].pop_front()));
                end
                if (oerr[k]) begin
                    if (q_er[k].size() == 0) cmp($sformatf("unexpected_frame_err%0d", k), NW'(1), '0);
                    else cmp($sformatf("frame_err_edge%0d", k), NW'(edge_n), NW'(q_er[k].pop_front()));
                end
                if (q_data[k].size() > 0 && q_data[k][0].at < edge_n) begin
                    cmp($sformatf("missed_pulse%0d", k), '0, NW'(1));
                    void'(q_data[k].pop_front());
                end
                if (q_ov[k].size() > 0 && q_ov[k][0] < edge_n) begin
                    cmp($sformatf("missed_overrun%0d", k), '0, NW'(1));
                    void'(q_ov[k].pop_front());
                end
                if (q_er[k].size() > 0 && q_er[k][0] < edge_n) begin
                    cmp($sformatf("missed_frame_err%0d", k), '0, NW'(1));
                    void'(q_er[k].pop_front());
                end
            end
            if (fin_req && !fin_done) begin
                cmp($sformatf("drain_frames%0d", k), NW'(q_data[k].size()), '0);
                cmp($sformatf("drain_overrun%0d", k), NW'(q_ov[k].size()), '0);
                cmp($sformatf("drain_frame_err%0d", k), NW'(q_er[k].size()), '0);
                cmp($sformatf("model_pending%0d", k), NW'(mpend[k]), '0);
            end
        end
        if (fin_req) fin_done = 1;
    end

    task automatic send(input logic [W-1:0] w, input logic last);
        @(posedge clk); #1;
        d = w; v = 1'b1; l = last;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk); #1;
            d = W'($urandom); v = 1'b0; l = 1'b0;
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            send(W'($urandom), i == N - 1);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Words 1..10 back to back
        for (int i = 0; i < N; i++) send(W'(i + 1), i == N - 1);
        idle(20);

        // Frame A then frame B immediately
        send_frame(0);
        send_frame(0);
        idle(30);

        // Three back-to-back frames: the long-guard instance drops the third
        repeat (3) send_frame(0);
        idle(70);

        // Alternating all-ones / all-zeros with random gaps
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) idle(1);
                send((i % 2 == 0) ? 16'hFFFF : 16'h0000, i == N - 1);
            end
        end
        idle(60);

        // Reset after word 6 of a frame
        for (int i = 0; i < 6; i++) send(W'($urandom), 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; v = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(0);
        idle(60);

`ifdef PACKER_LAST_CHECK_EN
        // Early i_last on word 7, then a correct frame
        for (int i = 0; i < 7; i++) send(W'($urandom), i == 6);
        send_frame(0);
        idle(60);
`endif

        // Random frames with random gaps
        repeat (4) send_frame(1);
        idle(100);

        fin_req = 1;
        repeat (3) @(posedge clk);
        if (!fin_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL final_drain: got not-run expected run");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/layer_output_packer.md
Name: layer_output_packer

Overview:
- Transmit-side feeder for the argmax stage.
- Collects a layer's neuron outputs as a serial stream of numInput words and packs them into one flat numInput*inputWidth bus.
- Presents that bus with a single-cycle valid pulse, in exactly the format the argmax stage consumes.
- Holds off the next pulse for a guard interval so an in-progress argmax search is never restarted; one pending frame is buffered during the guard.

Parameters:
- numInput, 10, number of words per frame (neurons in the layer).
- inputWidth, 16, bits per word.
- guardCycles, numInput+1, minimum cycles between o_data_valid pulses (argmax search duration).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_data  input  inputWidth  serial neuron output word.
- i_valid  input  1  i_data is valid this cycle; no backpressure, always accepted.
- o_data  output  numInput*inputWidth  packed frame; lane k = bits [k*inputWidth +: inputWidth] = k-th word received.
- o_data_valid  output  1  single-cycle pulse: o_data holds a new frame.
- o_overrun  output  1  single-cycle pulse: completed frame dropped because the pending slot was occupied.

Behaviour:
- Reset (async assert, sync release): o_data=0, o_data_valid=0, o_overrun=0, wr_cnt=0, pending_full=0, state=IDLE, guard_cnt=0.
- Reset mid-frame discards the partial frame and the pending frame.
- Collector, on each edge with i_valid=1:
  - writes i_data into collect lane wr_cnt.
  - if wr_cnt<numInput-1: wr_cnt+1.
  - if wr_cnt==numInput-1: wr_cnt=0 and the frame is complete.
- Frame completion, same edge:
  - pending slot empty, or being drained by the emitter this same edge: the full collect buffer, including the final word, is copied to pending; pending_full=1.
  - otherwise: the new frame is dropped, pending is kept, o_overrun=1 for one cycle.
- i_valid gaps are allowed anywhere; wr_cnt holds across gaps.
- Emitter FSM, two states:
  - IDLE: when pending_full=1, o_data<=pending, o_data_valid<=1, pending_full<=0, guard_cnt<=guardCycles-1, go to GUARD.
  - GUARD: o_data_valid<=0. If guard_cnt==0 go to IDLE, else guard_cnt-1.
- Pulse spacing: consecutive o_data_valid pulses are at least guardCycles+1 cycles apart (leading edge to leading edge).
- Latency: last word sampled at edge E; o_data_valid is high during the cycle after edge E+1 (2 edges) when the emitter is IDLE.
- o_data holds the last emitted frame until the next emission; it never changes while o_data_valid=0 except at reset.
- No arithmetic on data; words are copied bit-exact, unsigned/signed agnostic.
- guardCycles=0 is legal: the FSM returns to IDLE on the edge after emission.

Optional Feature:
- Macro: PACKER_LAST_CHECK_EN.
- Defined:
  - adds input i_last (1 bit, qualified by i_valid) and output o_frame_err (1-bit pulse).
  - i_last with wr_cnt!=numInput-1, or no i_last at wr_cnt==numInput-1: frame discarded, wr_cnt=0, o_frame_err=1 for one cycle, pending untouched.
- Undefined: neither port exists; framing is by count only.

Decomposition:
- Shared package mlp_pkg:
  - packer FSM state encoding (IDLE, GUARD).
  - default numInput/inputWidth constants shared with the argmax stage so both ends agree on lane order.
- One sub-module: packer_frame_collector (wr_cnt, collect buffer, completion strobe, optional last check).
- The top holds the pending slot, emitter FSM, guard counter and output registers.

Test Plan:
- Reset then 10 back-to-back words 1..10 -> one o_data_valid pulse 2 edges after word 10; lane0=1, lane9=10; o_data stable afterward.
- Frame A, then frame B immediately (B complete ~10 cycles after A's pulse, inside the 11-cycle guard) -> B pulse exactly guardCycles+1=12 cycles after A's pulse; no overrun.
- Three back-to-back frames with guardCycles forced large (40) -> frames 1 and 2 emitted, frame 3 dropped with one o_overrun pulse at its completion edge.
- Random i_valid gaps (50% duty) with words 0xFFFF,0x0000 alternating -> packed lanes bit-exact; single pulse per frame.
- Assert i_rst_n low after word 6 of a frame, release, send a full new frame -> only the new frame emitted, no stale lanes, no pulse during reset.
- PACKER_LAST_CHECK_EN defined, i_last on word 7 -> o_frame_err pulse, no o_data_valid; next correct frame emitted normally.
